// File: rtl/adder_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : adder_seq_pkg                                                  |
// | Purpose : Shared types and constants for the time-shared wide adder      |
// |           sequencer (adder_seq_ctrl) and its slice adder (adder_slice).  |
// | Contents: state_t       - FSM state encoding (2 bits)                    |
// |           C_DEF_WORDS   - default number of slices per operation         |
// |           C_DEF_SLICE   - default slice adder width in bits              |
// |           idx_width()   - ceil(log2(n)) clamped to a minimum of 1 bit    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package adder_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int C_DEF_WORDS = 4;
  localparam int C_DEF_SLICE = 8;

  // Counter width for values 0..n-1; a single-valued counter still needs one
  // bit so that the register has a legal declaration.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : adder_slice                                                    |
// | Purpose : Combinational WIDTH-bit adder with carry in and carry out.     |
// |           This is the only arithmetic element of the sequencer; it is    |
// |           reused once per cycle for every slice of a wide operation.     |
// | Params  : WIDTH  - slice width in bits                                   |
// | Ports   : a, b   in  WIDTH  slice operands                               |
// |           c_in   in  1      carry into bit 0                             |
// |           sum    out WIDTH  slice sum                                    |
// |           c_out  out 1      carry out of bit WIDTH-1                     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module adder_slice
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = C_DEF_SLICE
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // One extra result bit captures the carry; this maps onto a plain ripple
  // carry chain, which is the path the sequencer is timed against.
  logic [WIDTH:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
  assign sum    = w_full[WIDTH-1:0];
  assign c_out  = w_full[WIDTH];

endmodule

`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : adder_seq_ctrl                                                 |
// | Purpose : Wide (WORDS*SLICE bit) adder built by time-sharing a single    |
// |           SLICE-bit adder, one slice per cycle, carry chained through a  |
// |           register. Operands arrive on a valid/ready source handshake,   |
// |           the result leaves on a valid/ready sink handshake.             |
// | Params  : WORDS  - slices per operation (>= 1)                           |
// |           SLICE  - slice adder width in bits                             |
// | Ports   : clk, rst          clock, asynchronous active-high reset        |
// |           in_valid/in_ready operand handshake (ready only when idle)     |
// |           a, b, c_in        operands and carry in, latched on accept     |
// |           sub               (ADDER_SEQ_SUB_EN only) 1 = a - b - c_in     |
// |           out_valid/out_ready result handshake                           |
// |           sum, c_out        registered result and top carry              |
// |           busy              high while computing or holding a result     |
// | Config  : define ADDER_SEQ_SUB_EN to add the sub port (subtraction via   |
// |           inverted B slice and inverted initial carry).                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WORDS = C_DEF_WORDS,
  parameter int SLICE = C_DEF_SLICE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORDS*SLICE-1:0]   a,
  input  logic [WORDS*SLICE-1:0]   b,
  input  logic                     c_in,
`ifdef ADDER_SEQ_SUB_EN
  input  logic                     sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORDS*SLICE-1:0]   sum,
  output logic                     c_out,
  output logic                     busy
);

  localparam int C_WIDTH  = WORDS * SLICE;
  localparam int C_IDX_W  = idx_width(WORDS);
  localparam int C_BASE_W = idx_width(C_WIDTH);

  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(WORDS - 1);

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_next;

  logic [C_WIDTH-1:0]   r_a;
  logic [C_WIDTH-1:0]   r_b;
  logic [C_WIDTH-1:0]   r_sum;
  logic                 r_carry;
  logic                 r_c_out;
  logic [C_IDX_W-1:0]   r_idx;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_carry_init;
  logic [C_BASE_W-1:0]  w_base;
  logic [SLICE-1:0]     w_a_slice;
  logic [SLICE-1:0]     w_b_slice;
  logic [SLICE-1:0]     w_slice_sum;
  logic                 w_slice_cout;

`ifdef ADDER_SEQ_SUB_EN
  logic                 r_sub;

  // a - b - borrow == a + ~b + ~borrow; carry out of 1 then means no borrow.
  assign w_carry_init = sub ? ~c_in : c_in;
  assign w_b_slice    = r_sub ? ~r_b[w_base +: SLICE] : r_b[w_base +: SLICE];
`else
  assign w_carry_init = c_in;
  assign w_b_slice    = r_b[w_base +: SLICE];
`endif

  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_idx == C_LAST_IDX);
  assign w_base    = C_BASE_W'(r_idx) * C_BASE_W'(SLICE);
  assign w_a_slice = r_a[w_base +: SLICE];

  // ---------------------------------------------------------------------
  // Shared slice adder, fed by the idx-selected operand slices
  // ---------------------------------------------------------------------
  adder_slice #(
    .WIDTH (SLICE)
  ) u_slice (
    .a     (w_a_slice),
    .b     (w_b_slice),
    .c_in  (r_carry),
    .sum   (w_slice_sum),
    .c_out (w_slice_cout)
  );

  // ---------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;

    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_idx   <= '0;
`ifdef ADDER_SEQ_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= w_carry_init;
        r_idx   <= '0;
`ifdef ADDER_SEQ_SUB_EN
        r_sub   <= sub;
`endif
      end

      // The result register is overwritten slice by slice; outside RUN it
      // holds the last completed result.
      if (r_state == S_RUN) begin
        r_sum[w_base +: SLICE] <= w_slice_sum;
        r_carry                <= w_slice_cout;
        if (w_last) begin
          r_c_out <= w_slice_cout;
          // Park the counter at 0 so it never steps past WORDS-1.
          r_idx   <= '0;
        end else begin
          r_idx   <= r_idx + 1'b1;
        end
      end
    end
  end

  assign sum   = r_sum;
  assign c_out = r_c_out;

endmodule

`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_adder_seq_ctrl                                              |
// | Purpose : Self-checking bench for adder_seq_ctrl (WORDS=4, SLICE=8).     |
// |           Expected results are pushed to a scoreboard queue when the     |
// |           operands are accepted and popped when out_valid appears.       |
// | Config  : the subtraction cases run only when ADDER_SEQ_SUB_EN is set.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_adder_seq_ctrl;

  localparam int C_WORDS  = 4;
  localparam int C_SLICE  = 8;
  localparam int C_W      = C_WORDS * C_SLICE;
  localparam int C_BUDGET = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic           r_in_valid;
  logic           r_out_ready;
  logic           r_c_in;
  logic           r_sub;
  logic [C_W-1:0] r_a;
  logic [C_W-1:0] r_b;

  logic           w_in_ready;
  logic           w_out_valid;
  logic           w_c_out;
  logic           w_busy;
  logic [C_W-1:0] w_sum;

  logic [C_W:0]   sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl #(
    .WORDS (C_WORDS),
    .SLICE (C_SLICE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (r_in_valid),
    .in_ready  (w_in_ready),
    .a         (r_a),
    .b         (r_b),
    .c_in      (r_c_in),
`ifdef ADDER_SEQ_SUB_EN
    .sub       (r_sub),
`endif
    .out_valid (w_out_valid),
    .out_ready (r_out_ready),
    .sum       (w_sum),
    .c_out     (w_c_out),
    .busy      (w_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: {carry, sum} of a + b + c_in, or a + ~b + ~c_in for subtract.
  function automatic logic [C_W:0] model(input logic [C_W-1:0] a, input logic [C_W-1:0] b,
                                         input logic cin, input logic sub);
    logic [C_W-1:0] bb;
    logic           cc;
    bb = sub ? ~b : b;
    cc = sub ? ~cin : cin;
    return {1'b0, a} + {1'b0, bb} + {{C_W{1'b0}}, cc};
  endfunction

  // Issue one operation from IDLE, wait for the result, optionally stall the
  // sink for 'hold' cycles, then complete the output handshake.
  task automatic run_op(input logic [C_W-1:0] a, input logic [C_W-1:0] b,
                        input logic cin, input logic sub, input int hold);
    logic [C_W:0] exp;
    int           lat;
    check("in_ready_pre", w_in_ready, 1);
    r_a         = a;
    r_b         = b;
    r_c_in      = cin;
    r_sub       = sub;
    r_in_valid  = 1'b1;
    r_out_ready = (hold == 0);
    sb_q.push_back(model(a, b, cin, sub));
    @(posedge clk); #1;
    // Junk on the operand inputs must be ignored while busy.
    r_in_valid = 1'b0;
    r_a        = $urandom;
    r_b        = $urandom;
    r_c_in     = 1'($urandom_range(0, 1));
    r_sub      = ~sub;
    check("busy_run", w_busy, 1);
    check("in_ready_run", w_in_ready, 0);
    lat = 0;
    while (!w_out_valid && lat < C_BUDGET) begin
      @(posedge clk); #1;
      lat++;
    end
    exp = sb_q.pop_front();
    if (!w_out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", lat, C_WORDS);
    check("sum", w_sum, exp[C_W-1:0]);
    check("c_out", w_c_out, exp[C_W]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", w_out_valid, 1);
      check("hold_in_ready", w_in_ready, 0);
      check("hold_sum", w_sum, exp[C_W-1:0]);
      check("hold_c_out", w_c_out, exp[C_W]);
    end
    r_out_ready = 1'b1;
    @(posedge clk); #1;
    check("in_ready_post", w_in_ready, 1);
    check("out_valid_post", w_out_valid, 0);
    check("sum_kept", w_sum, exp[C_W-1:0]);
    r_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst         = 1'b1;
    r_in_valid  = 1'b0;
    r_out_ready = 1'b0;
    r_c_in      = 1'b0;
    r_sub       = 1'b0;
    r_a         = '0;
    r_b         = '0;

    // 1. Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", w_in_ready, 1);
    check("rst_out_valid", w_out_valid, 0);
    check("rst_busy", w_busy, 0);
    check("rst_sum", w_sum, 0);
    check("rst_c_out", w_c_out, 0);

    // 2./3. Carry across a slice boundary and through all slices
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);

    // 4. Sink stall, then back-to-back random operations
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 5);
    for (int i = 0; i < 10; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 0);
    end

    // 5. Reset during the second RUN cycle aborts the operation
    r_a        = 32'hFFFF_FFFF;
    r_b        = 32'h0000_0001;
    r_c_in     = 1'b0;
    r_sub      = 1'b0;
    r_in_valid = 1'b1;
    @(posedge clk); #1;
    r_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", w_in_ready, 1);
    check("abort_out_valid", w_out_valid, 0);
    check("abort_busy", w_busy, 0);
    check("abort_sum", w_sum, 0);
    check("abort_c_out", w_c_out, 0);
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (w_out_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 0);

`ifdef ADDER_SEQ_SUB_EN
    // 6. Subtraction with borrow-in
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
    run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
